// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 16-bit five-stage pipeline.
//
// Owns the PC register and the IF/ID pipeline register. It also detects HLT at
// fetch time and freezes fetch once HLT has been seen.
//
// Ports:
//   clk          system clock; all state updates on the rising edge
//   rst          synchronous, active-high reset (highest priority)
//   stall        hold PC and IF/ID register this cycle
//   redirect     taken branch/jump resolved in EX (beats stall)
//   redirect_pc  redirect target; bit 0 is forced to 0 when loaded
//   imem_addr    instruction-memory address, always the registered PC
//   imem_data    instruction word read combinationally from imem_addr
//   pc_out       current PC register value
//   IF_instr     instruction fetched this cycle (= imem_data)
//   ID_instr     IF/ID registered instruction
//   ID_pc_plus2  IF/ID registered PC+2 of ID_instr
//   ID_valid     ID_instr is a real instruction (0 = bubble)
//   halted       HLT has been fetched; fetch is frozen
//
// Optional build macro FETCH_STATS_EN adds the following outputs:
//   stat_cycles  non-reset cycles seen while not halted (saturating)
//   stat_fetched normal-path fetches loaded into ID (saturating)

module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF,
    parameter logic [15:0] NOP_INSTR   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] pc_out,
    output logic [15:0] IF_instr,
    output logic [15:0] ID_instr,
    output logic [15:0] ID_pc_plus2,
    output logic        ID_valid,
    output logic        halted
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] stat_cycles,
    output logic [15:0] stat_fetched
`endif
);

    logic [15:0] pc;
    logic [15:0] pc_seq;
    logic        fetch_hlt;

    assign pc_seq    = pc + 16'd2;
    assign fetch_hlt = (imem_data[15:12] == HALT_OPCODE);

    // The address always comes straight from the PC register. Stall and
    // redirect only affect the next PC, so there is no combinational path
    // from them to the memory address.
    assign imem_addr = pc;
    assign pc_out    = pc;
    assign IF_instr  = imem_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            ID_instr    <= NOP_INSTR;
            ID_pc_plus2 <= 16'h0000;
            ID_valid    <= 1'b0;
            halted      <= 1'b0;
        end else if (redirect) begin
            // The instruction fetched this cycle is on the wrong path. Flush
            // it and drop any HLT that was fetched on that path.
            pc       <= redirect_pc & 16'hFFFE;
            ID_instr <= NOP_INSTR;
            ID_valid <= 1'b0;
            halted   <= 1'b0;
        end else if (stall) begin
            // everything holds
        end else if (halted) begin
            // PC stays on the HLT address; only bubbles follow HLT down the pipe
            ID_instr <= NOP_INSTR;
            ID_valid <= 1'b0;
        end else begin
            ID_instr    <= imem_data;
            ID_pc_plus2 <= pc_seq;
            ID_valid    <= 1'b1;
            if (fetch_hlt) begin
                halted <= 1'b1;
            end else begin
                pc <= pc_seq;
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic fetch_now;

    assign fetch_now = !redirect && !stall && !halted;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cycles  <= 16'h0000;
            stat_fetched <= 16'h0000;
        end else begin
            // The cycle that fetches HLT is still counted, because halted is
            // 0 during that cycle.
            if (!halted && stat_cycles != 16'hFFFF) begin
                stat_cycles <= stat_cycles + 16'd1;
            end
            if (fetch_now && stat_fetched != 16'hFFFF) begin
                stat_fetched <= stat_fetched + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] pc_out;
    logic [15:0] IF_instr;
    logic [15:0] ID_instr;
    logic [15:0] ID_pc_plus2;
    logic        ID_valid;
    logic        halted;
`ifdef FETCH_STATS_EN
    logic [15:0] stat_cycles;
    logic [15:0] stat_fetched;
`endif

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .pc_out      (pc_out),
        .IF_instr    (IF_instr),
        .ID_instr    (ID_instr),
        .ID_pc_plus2 (ID_pc_plus2),
        .ID_valid    (ID_valid),
        .halted      (halted)
`ifdef FETCH_STATS_EN
        ,
        .stat_cycles (stat_cycles),
        .stat_fetched(stat_fetched)
`endif
    );

    always #5 clk = ~clk;

    // Small instruction memory. It is aliased on address bits [8:1].
    logic [15:0] mem [256];
    assign imem_data = mem[imem_addr[8:1]];

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state
    logic [15:0] m_pc, m_id, m_p2;
    logic        m_v, m_h;
    int          m_cyc, m_fet;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] rand_word(input int hlt_pct);
        logic [15:0] w;
        w = 16'($urandom);
        if (int'($urandom_range(99)) < hlt_pct) w[15:12] = 4'hF;
        else w[15:12] = 4'($urandom_range(14));
        return w;
    endfunction

    function automatic logic [15:0] word_at(input logic [15:0] a);
        logic [7:0] idx;
        idx = a[8:1];
        return mem[idx];
    endfunction

    // One clock: apply inputs, advance the model by the priority rules, and
    // compare every output #1 after the edge.
    task automatic step(input logic r, input logic st, input logic rd, input logic [15:0] rpc);
        logic [15:0] w;
        rst = r; stall = st; redirect = rd; redirect_pc = rpc;
        w = word_at(m_pc);
        if (r) begin
            m_pc = 16'h0000; m_id = NOP; m_p2 = 16'h0000; m_v = 1'b0; m_h = 1'b0;
            m_cyc = 0; m_fet = 0;
        end else begin
            if (!m_h && m_cyc < 65535) m_cyc++;
            if (rd) begin
                m_pc = {rpc[15:1], 1'b0}; m_id = NOP; m_v = 1'b0; m_h = 1'b0;
            end else if (st) begin
            end else if (m_h) begin
                m_id = NOP; m_v = 1'b0;
            end else begin
                m_id = w; m_p2 = m_pc + 16'd2; m_v = 1'b1;
                if (m_fet < 65535) m_fet++;
                if (w[15:12] == 4'hF) m_h = 1'b1;
                else m_pc = m_pc + 16'd2;
            end
        end
        @(posedge clk);
        #1;
        chk("pc_out", pc_out, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("IF_instr", IF_instr, word_at(m_pc));
        chk("ID_instr", ID_instr, m_id);
        chk("ID_pc_plus2", ID_pc_plus2, m_p2);
        chk("ID_valid", {15'd0, ID_valid}, {15'd0, m_v});
        chk("halted", {15'd0, halted}, {15'd0, m_h});
`ifdef FETCH_STATS_EN
        chk("stat_cycles", stat_cycles, 16'(m_cyc));
        chk("stat_fetched", stat_fetched, 16'(m_fet));
`endif
    endtask

    task automatic norm();
        step(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    int vcount;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = rand_word(0);
        m_pc = 16'h0000; m_id = NOP; m_p2 = 16'h0000; m_v = 1'b0; m_h = 1'b0;
        m_cyc = 0; m_fet = 0;

        // Reset for two cycles, then sequential fetch
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b1, 1'b1, 16'h1234);
        chk("rst_pc", pc_out, 16'h0000);
        chk("rst_valid", {15'd0, ID_valid}, 16'h0000);
        norm();
        chk("seq_pc1", pc_out, 16'h0002);
        chk("seq_p2_1", ID_pc_plus2, 16'h0002);
        chk("seq_id1", ID_instr, mem[0]);
        norm();
        chk("seq_pc2", pc_out, 16'h0004);
        chk("seq_p2_2", ID_pc_plus2, 16'h0004);
        norm();
        // Stall at 0006
        chk("stall_at", pc_out, 16'h0006);
        repeat (3) step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("stall_pc", pc_out, 16'h0006);
        chk("stall_id", ID_instr, mem[2]);
        norm();
        chk("post_stall_pc", pc_out, 16'h0008);

        // Redirect beats stall; the odd target is forced even
        step(1'b0, 1'b1, 1'b1, 16'h0031);
        chk("redir_pc", pc_out, 16'h0030);
        chk("redir_valid", {15'd0, ID_valid}, 16'h0000);
        chk("redir_id", ID_instr, NOP);

        // HLT at 000A
        mem[5] = 16'hF000;
        step(1'b0, 1'b0, 1'b1, 16'h000A);
        norm();
        chk("hlt_id", ID_instr, 16'hF000);
        chk("hlt_valid", {15'd0, ID_valid}, 16'h0001);
        chk("hlt_halted", {15'd0, halted}, 16'h0001);
        vcount = 0;
        repeat (10) begin
            norm();
            if (ID_valid) vcount++;
        end
        chk("hlt_frozen_pc", pc_out, 16'h000A);
        chk("hlt_bubbles", 16'(vcount), 16'h0000);

        // Squashed HLT: redirect to 0100 right after HLT was fetched
        mem[128] = 16'h1111;
        mem[129] = 16'h2222;
        step(1'b0, 1'b0, 1'b1, 16'h000A);
        norm();
        chk("sq_halted1", {15'd0, halted}, 16'h0001);
        step(1'b0, 1'b0, 1'b1, 16'h0100);
        chk("sq_halted0", {15'd0, halted}, 16'h0000);
        chk("sq_pc", pc_out, 16'h0100);
        norm();
        chk("sq_resume", pc_out, 16'h0102);

        // Wrap from FFFE to 0000
        mem[255] = 16'h1234;
        step(1'b0, 1'b0, 1'b1, 16'hFFFE);
        norm();
        chk("wrap_pc", pc_out, 16'h0000);
        chk("wrap_p2", ID_pc_plus2, 16'h0000);

        // Random traffic with some HLT words in memory
        for (int i = 0; i < 256; i++) mem[i] = rand_word(6);
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(99) < 2, $urandom_range(99) < 25,
                 $urandom_range(99) < 10, 16'($urandom));
        end

`ifdef FETCH_STATS_EN
        // 5 fetches, 2 stall cycles, then HLT
        for (int i = 0; i < 5; i++) mem[i] = 16'h1000 + 16'(i);
        mem[5] = 16'hF000;
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        norm(); norm(); norm();
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        norm(); norm(); norm();
        repeat (5) norm();
        chk("stat_fetched_hlt", stat_fetched, 16'd6);
        chk("stat_cycles_hlt", stat_cycles, 16'd8);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 16-bit five-stage pipeline.
- Owns the PC register, drives the instruction-memory address, detects HLT at fetch, and owns the IF/ID pipeline register.
- Consumes stall from hazard detection and taken-branch redirect from EX.
- Produces the IF instruction, PC and halt status seen by the top level and the pipeline trace bench, plus the ID-side instruction, valid bit and PC+2.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OPCODE, 4'hF, instr[15:12] value identifying HLT.
- NOP_INSTR, 16'h0000, instruction inserted into ID on flush or after halt.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and IF/ID register this cycle.
- redirect  input  1  taken branch/jump resolved in EX.
- redirect_pc  input  16  target PC for redirect.
- imem_addr  output  16  instruction-memory address; equals pc_out.
- imem_data  input  16  instruction word; combinational read of imem_addr, same cycle.
- pc_out  output  16  current PC register value.
- IF_instr  output  16  instruction fetched this cycle; equals imem_data.
- ID_instr  output  16  IF/ID registered instruction.
- ID_pc_plus2  output  16  IF/ID registered PC+2 of ID_instr.
- ID_valid  output  1  ID_instr is a real instruction (0 = bubble).
- halted  output  1  HLT has been fetched; fetch frozen.

Behaviour:
- Reset values, applied at the first rising edge with rst=1:
  - pc_out=RESET_PC, ID_instr=NOP_INSTR, ID_pc_plus2=0, ID_valid=0, halted=0.
  - rst has priority over everything, including mid-halt and mid-stall.
- Address arithmetic: byte addressing, pc_next_seq = pc_out+2, modulo 2^16 (16'hFFFE+2 = 16'h0000). redirect_pc[0] is forced to 0 when loaded.
- Per-cycle priority (non-reset): redirect > stall > halted > normal.
- redirect=1:
  - pc <= {redirect_pc[15:1],1'b0}.
  - ID_instr <= NOP_INSTR, ID_valid <= 0 (flush the wrong-path fetch).
  - halted <= 0: a HLT fetched on the wrong path is squashed.
  - Applies even when stall=1 in the same cycle.
- stall=1 (no redirect): pc, ID_instr, ID_pc_plus2, ID_valid and halted all hold.
- halted=1 (no redirect, no stall):
  - pc holds (stays at the HLT address).
  - ID_instr <= NOP_INSTR, ID_valid <= 0.
  - IF_instr still reflects imem_data.
- Normal:
  - ID_instr <= imem_data, ID_pc_plus2 <= pc_out+2, ID_valid <= 1.
  - If imem_data[15:12]==HALT_OPCODE: halted <= 1 and pc holds. Otherwise pc <= pc_out+2.
- HLT behaviour: HLT enters ID exactly once with ID_valid=1. Subsequent bubbles let it drain to MEM/WB, where the top-level hlt output is generated downstream.
- Latency:
  - ID_instr is valid 1 cycle after the fetch.
  - First fetch from RESET_PC occurs in the first cycle after rst deasserts.
- The block is fully synchronous, with no combinational path from stall or redirect to imem_addr. imem_addr always equals the registered pc.

Optional Feature:
- Macro FETCH_STATS_EN.
- When defined, adds two outputs:
  - stat_cycles (16): counts every non-reset cycle until halted=1, then freezes.
  - stat_fetched (16): counts normal-path fetches, i.e. cycles where ID_valid is loaded with 1.
  - Both reset to 0 and saturate at 16'hFFFF.
- When undefined, both ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- Reset/sequential fetch: rst held 2 cycles; imem holds non-HLT words.
  - pc_out sequence 0000,0002,0004.
  - ID_instr lags IF_instr by 1 cycle; ID_pc_plus2 = 0002,0004.
  - ID_valid=0 in the first cycle, then 1.
- Stall: stall=1 for 3 cycles at pc=0006.
  - pc_out stays 0006, ID_instr is unchanged.
  - After release, pc_out = 0008 on the next edge.
- Redirect over stall: redirect=1, redirect_pc=0x0031, stall=1 in the same cycle.
  - Next pc_out=0x0030, ID_valid=0, ID_instr=NOP_INSTR.
- HLT: word 0xF000 at 0x000A.
  - ID_instr=F000 with ID_valid=1 for exactly one cycle.
  - halted=1; pc_out frozen at 000A for ≥10 cycles; ID_valid stays 0.
- Squashed HLT and wrap:
  - HLT fetched, then redirect to 0x0100 the next cycle: halted returns to 0 and fetch resumes at 0100.
  - Separately, redirect to FFFE with a non-HLT word there: next pc_out=0000.
- FETCH_STATS_EN: 5 fetches, 2 stall cycles, then HLT.
  - stat_fetched=6, counting the HLT.
  - stat_cycles frozen at 8 from halt onward, counting stall and HLT-fetch cycles.
